// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline writeback path.
// Holds the MEM/WB control-bit positions, the special register numbers,
// the datapath widths and a small helper that unpacks the control field.
package mips_pkg;

    // Datapath geometry
    localparam int DW    = 32;   // data width
    localparam int PCW   = 15;   // width of the pc field carried by MEM/WB
    localparam int NREGS = 32;   // architectural registers
    localparam int AW    = 5;    // register address width

    // Bit positions inside control_wb
    localparam int CTL_REG_WRITE  = 0;
    localparam int CTL_MEM_TO_REG = 1;
    localparam int CTL_LINK       = 2;

    // Special register numbers
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_RA   = 5'd31;

    // Decoded view of control_wb
    typedef struct packed {
        logic link;
        logic mem_to_reg;
        logic reg_write;
    } wb_ctl_t;

    function automatic wb_ctl_t unpack_ctl(input logic [2:0] ctl);
        wb_ctl_t c;
        c.link       = ctl[CTL_LINK];
        c.mem_to_reg = ctl[CTL_MEM_TO_REG];
        c.reg_write  = ctl[CTL_REG_WRITE];
        return c;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one synchronous write port, two
// asynchronous read ports, register 0 reads as zero and ignores writes.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, clears every register
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data (combinational)
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data (combinational)
module regfile_2r1w #(
    parameter int NREGS = mips_pkg::NREGS,
    parameter int DW    = mips_pkg::DW,
    parameter int AW    = mips_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    import mips_pkg::*;

    logic [DW-1:0] regs [NREGS];

    // NOTE: clearing every entry on reset turns this array into discrete
    // flops rather than an inferable RAM; the core relies on a known-zero
    // register file after reset, so the clear is intentional.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            // NOTE: state updates use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            regs[waddr] <= wdata;
        end
    end

    // r0 is hardwired to zero independently of what the array holds.
    assign rdata_a = (raddr_a == REG_ZERO) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == REG_ZERO) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Selects the writeback value (ALU result, load data or link address) and
// destination from the MEM/WB outputs, commits it to the register file,
// serves the two decode read ports with same-cycle write-through bypass,
// exports the committed write for forwarding and counts retired writes.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   control_wb     in   {link, mem_to_reg, reg_write}
//   mem_data_wb    in   load data
//   alu_output_wb  in   ALU result
//   rd_wb          in   destination register
//   pc_wb          in   return address (already incremented)
//   rs_addr        in   decode read address, port rs
//   rt_addr        in   decode read address, port rt
//   rs_data        out  rs read data (combinational, bypassed)
//   rt_data        out  rt read data (combinational, bypassed)
//   wb_en          out  a write commits this cycle
//   wb_dest        out  decoded destination (valid even when wb_en=0)
//   wb_data        out  decoded value (valid even when wb_en=0)
//   retire_count   out  number of committed writes, wraps at 2^32
module wb_regfile #(
    parameter int NREGS = mips_pkg::NREGS,
    parameter int DW    = mips_pkg::DW,
    parameter int PCW   = mips_pkg::PCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             control_wb,
    input  logic [DW-1:0]          mem_data_wb,
    input  logic [DW-1:0]          alu_output_wb,
    input  logic [mips_pkg::AW-1:0] rd_wb,
    input  logic [PCW-1:0]         pc_wb,
    input  logic [mips_pkg::AW-1:0] rs_addr,
    input  logic [mips_pkg::AW-1:0] rt_addr,
    output logic [DW-1:0]          rs_data,
    output logic [DW-1:0]          rt_data,
    output logic                   wb_en,
    output logic [mips_pkg::AW-1:0] wb_dest,
    output logic [DW-1:0]          wb_data,
    output logic [31:0]            retire_count
);
    import mips_pkg::*;

    wb_ctl_t       ctl;
    logic [DW-1:0] rf_rs_data;
    logic [DW-1:0] rf_rt_data;
    logic [31:0]   retire_q;

    assign ctl = unpack_ctl(control_wb);

    // Destination and value selection. Link overrides both the destination
    // and the value so a jal/jalr always lands its return address in r31.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wb_dest = rd_wb;
        wb_data = alu_output_wb;
        if (ctl.link) begin
            wb_dest = REG_RA;
            wb_data = {{(DW-PCW){1'b0}}, pc_wb};
        end else if (ctl.mem_to_reg) begin
            wb_data = mem_data_wb;
        end
    end

    // Writes to r0 are dropped here, not just in the array, so they are
    // neither forwarded nor counted. Reset suppresses the commit outright.
    assign wb_en = (ctl.reg_write | ctl.link) & (wb_dest != REG_ZERO) & ~rst;

    regfile_2r1w #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_dest),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .rdata_a (rf_rs_data),
        .raddr_b (rt_addr),
        .rdata_b (rf_rt_data)
    );

    // Write-through bypass: decode sees the value being committed this cycle.
    // r0 needs no special case here because wb_en is never set for r0.
    always_comb begin
        rs_data = rf_rs_data;
        rt_data = rf_rt_data;
        if (wb_en && (rs_addr == wb_dest)) begin
            rs_data = wb_data;
        end
        if (wb_en && (rt_addr == wb_dest)) begin
            rt_data = wb_data;
        end
    end

    // Retired-write counter, free-running wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (wb_en) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by a
// randomized stream, all compared against an array-based reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [2:0]  control_wb;
    logic [31:0] mem_data_wb;
    logic [31:0] alu_output_wb;
    logic [4:0]  rd_wb;
    logic [14:0] pc_wb;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [31:0] retire_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: architectural register contents and retired count.
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    wb_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .control_wb    (control_wb),
        .mem_data_wb   (mem_data_wb),
        .alu_output_wb (alu_output_wb),
        .rd_wb         (rd_wb),
        .pc_wb         (pc_wb),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // What the architectural rules say a read of register a returns while
    // a given write is (or is not) being committed.
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic en,
                                               input logic [4:0] dest,
                                               input logic [31:0] data);
        if (a == 5'd0)               return 32'd0;
        if (en && (a == dest))       return data;
        return model_regs[a];
    endfunction

    // Drive one MEM/WB beat away from the active edge, check every output,
    // then let the edge happen and advance the model.
    task automatic step(input logic r, input logic [2:0] c,
                        input logic [31:0] md, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [14:0] pc,
                        input logic [4:0] ra, input logic [4:0] rb);
        logic        e_en;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        @(negedge clk);
        rst           = r;
        control_wb    = c;
        mem_data_wb   = md;
        alu_output_wb = alu;
        rd_wb         = rd;
        pc_wb         = pc;
        rs_addr       = ra;
        rt_addr       = rb;
        e_dest = c[2] ? 5'd31 : rd;
        if (c[2])      e_data = {17'd0, pc};
        else if (c[1]) e_data = md;
        else           e_data = alu;
        e_en = (c[0] || c[2]) && (e_dest != 5'd0) && !r;
        #1;
        check("wb_en",        {31'd0, wb_en},   {31'd0, e_en});
        check("wb_dest",      {27'd0, wb_dest}, {27'd0, e_dest});
        check("wb_data",      wb_data,          e_data);
        check("rs_data",      rs_data,          model_read(ra, e_en, e_dest, e_data));
        check("rt_data",      rt_data,          model_read(rb, e_en, e_dest, e_data));
        check("retire_count", retire_count,     model_count);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_count = 32'd0;
        end else if (e_en) begin
            model_regs[e_dest] = e_data;
            model_count = model_count + 32'd1;
        end
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        step(1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 15'd0, ra, rb);
    endtask

    initial begin
        rst = 1'b1; control_wb = 3'b000; mem_data_wb = '0; alu_output_wb = '0;
        rd_wb = '0; pc_wb = '0; rs_addr = '0; rt_addr = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
        repeat (2) @(posedge clk);

        // Reset state: every register reads zero through both ports.
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // ALU write with same-cycle bypass, then stored read and count.
        step(1'b0, 3'b001, 32'd0, 32'h1234_5678, 5'd5, 15'd0, 5'd5, 5'd5);
        idle(5'd5, 5'd0);
        check("count_after_first", retire_count, 32'd1);

        // Load data takes priority over ALU result.
        step(1'b0, 3'b011, 32'hDEAD_BEEF, 32'h1, 5'd7, 15'd0, 5'd7, 5'd5);
        idle(5'd7, 5'd7);
        check("r7_load", rs_data, 32'hDEAD_BEEF);

        // Link goes to r31 regardless of rd; r9 stays untouched.
        step(1'b0, 3'b100, 32'h5, 32'h6, 5'd9, 15'h1ABC, 5'd9, 5'd31);
        idle(5'd31, 5'd9);
        check("r31_link", rs_data, 32'h0000_1ABC);

        // Write to r0 is discarded.
        step(1'b0, 3'b001, 32'd0, 32'h0000_FFFF, 5'd0, 15'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd7);

        // Back-to-back writes to one register: last one wins, both counted.
        step(1'b0, 3'b001, 32'd0, 32'h0000_0055, 5'd3, 15'd0, 5'd3, 5'd1);
        step(1'b0, 3'b011, 32'h0000_0066, 32'd0, 5'd3, 15'd0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // Reset coinciding with a write: reset wins.
        step(1'b1, 3'b001, 32'd0, 32'h0000_00AA, 5'd3, 15'd0, 5'd3, 5'd31);
        idle(5'd3, 5'd31);
        check("r3_after_rst", rs_data, 32'd0);
        check("count_after_rst", retire_count, 32'd0);

        // Counter wrap: the last idle left control at 000, so no write is
        // pending while the counter is preloaded.
        #1 force dut.retire_q = 32'hFFFF_FFFF;
        #1 release dut.retire_q;
        model_count = 32'hFFFF_FFFF;
        step(1'b0, 3'b001, 32'd0, 32'h0000_0042, 5'd4, 15'd0, 5'd4, 5'd0);
        idle(5'd4, 5'd0);
        check("count_wrap", retire_count, 32'd0);

        // Randomized stream with occasional reset; destinations and read
        // addresses are concentrated on a few registers to exercise bypass.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic [4:0]  rd, ra, rb;
            r  = ($urandom_range(0, 31) == 0);
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step(r, 3'($urandom), $urandom, $urandom, rd, 15'($urandom), ra, rb);
        end
        idle(5'd31, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
